// File: rtl/btb_sat.sv
// -----------------------------------------------------------------------------
// btb_sat -- small fully-associative branch target buffer with 2-bit
// saturating direction counters.
//
// Each entry holds a valid bit, a full-PC tag, a target and a 2-bit counter.
// Lookup is purely combinational on registered state (no bypass of an update
// made in the same cycle). Resolved branches update the table: a hit trains
// the counter (and refreshes the target when taken), a taken miss allocates
// an entry (lowest invalid slot first, otherwise a round-robin victim).
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset (priority over everything)
//   lookup_pc      fetch PC to predict
//   btb_hit        a valid entry's tag equals lookup_pc
//   predict_taken  btb_hit and counter bit[1] of the matching entry
//   btb_target_out target of the matching entry, 0 on miss
//   upd_valid      resolved-branch update strobe
//   upd_pc         resolved branch PC
//   upd_taken      resolved branch direction
//   upd_target     resolved branch target
//   flush          clear all valid bits at the next edge (drops any update)
//   valid_count    registered popcount of the valid bits
// -----------------------------------------------------------------------------
module btb_sat #(
    parameter int unsigned N_ENTRIES  = 8,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter logic [1:0]  CTR_INIT   = 2'b10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDR_WIDTH-1:0]         lookup_pc,
    output logic                          btb_hit,
    output logic                          predict_taken,
    output logic [ADDR_WIDTH-1:0]         btb_target_out,
    input  logic                          upd_valid,
    input  logic [ADDR_WIDTH-1:0]         upd_pc,
    input  logic                          upd_taken,
    input  logic [ADDR_WIDTH-1:0]         upd_target,
    input  logic                          flush,
    output logic [$clog2(N_ENTRIES):0]    valid_count
);

    localparam int unsigned IDX_W = $clog2(N_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Table state
    logic [N_ENTRIES-1:0]  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] tag_q    [N_ENTRIES];
    logic [ADDR_WIDTH-1:0] tag_d    [N_ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [N_ENTRIES];
    logic [ADDR_WIDTH-1:0] target_d [N_ENTRIES];
    logic [1:0]            ctr_q    [N_ENTRIES];
    logic [1:0]            ctr_d    [N_ENTRIES];
    logic [IDX_W-1:0]      victim_q, victim_d;
    logic [CNT_W-1:0]      valid_count_q, valid_count_d;

    // Search results
    logic             look_found;
    logic [IDX_W-1:0] look_idx;
    logic             upd_found;
    logic [IDX_W-1:0] upd_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] alloc_idx;

    // Priority searches: the first match in ascending index order wins, so
    // the lowest index is chosen when several entries qualify.
    always_comb begin
        look_found = 1'b0;
        look_idx   = '0;
        upd_found  = 1'b0;
        upd_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(N_ENTRIES); i++) begin
            if (!look_found && valid_q[i] && (tag_q[i] == lookup_pc)) begin
                look_found = 1'b1;
                look_idx   = IDX_W'(i);
            end
            if (!upd_found && valid_q[i] && (tag_q[i] == upd_pc)) begin
                upd_found = 1'b1;
                upd_idx   = IDX_W'(i);
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Lookup outputs: registered state only.
    always_comb begin
        btb_hit        = look_found;
        predict_taken  = look_found & ctr_q[look_idx][1];
        btb_target_out = look_found ? target_q[look_idx] : '0;
    end

    // Next-state for the table.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        victim_d  = victim_q;
        alloc_idx = free_found ? free_idx : victim_q;

        if (flush) begin
            // Only valid bits clear; payload and victim pointer are kept.
            valid_d = '0;
        end else if (upd_valid) begin
            if (upd_found) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    end
                    target_d[upd_idx] = upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[alloc_idx]  = 1'b1;
                tag_d[alloc_idx]    = upd_pc;
                target_d[alloc_idx] = upd_target;
                ctr_d[alloc_idx]    = CTR_INIT;
                // The victim pointer only moves when it was actually used;
                // the power-of-two size makes the wrap implicit.
                if (!free_found) begin
                    victim_d = victim_q + IDX_W'(1);
                end
            end
        end

        valid_count_d = '0;
        for (int i = 0; i < int'(N_ENTRIES); i++) begin
            valid_count_d = valid_count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q       <= '0;
            victim_q      <= '0;
            valid_count_q <= '0;
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else begin
            valid_q       <= valid_d;
            victim_q      <= victim_d;
            valid_count_q <= valid_count_d;
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    assign valid_count = valid_count_q;

endmodule

// File: tb/tb_btb_sat.sv
// -----------------------------------------------------------------------------
// tb_btb_sat -- directed self-checking bench for btb_sat (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are compared 1 time
// unit after the inputs settle, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_btb_sat;

    localparam int AW = 24;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] lookup_pc;
    logic          btb_hit;
    logic          predict_taken;
    logic [AW-1:0] btb_target_out;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          flush;
    logic [3:0]    valid_count;

    int errors = 0;
    int checks = 0;

    btb_sat dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .lookup_pc      (lookup_pc),
        .btb_hit        (btb_hit),
        .predict_taken  (predict_taken),
        .btb_target_out (btb_target_out),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .flush          (flush),
        .valid_count    (valid_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic do_update(input logic [AW-1:0] pc, input logic taken,
                             input logic [AW-1:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic look(input logic [AW-1:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Update presented during reset must be lost.
        reset_n    = 1'b0;
        upd_valid  = 1'b1;
        upd_pc     = 24'h000100;
        upd_taken  = 1'b1;
        upd_target = 24'h000200;
        tick();
        tick();
        look(24'h000100);
        checks++;
        if ({btb_hit, predict_taken, btb_target_out} !== {1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_during_lookup: got %h expected %h",
                     {btb_hit, predict_taken, btb_target_out}, {1'b0, 1'b0, 24'h0});
        end
        reset_n   = 1'b1;
        upd_valid = 1'b0;
        tick();
        look(24'h000100);
        checks++;
        if ({btb_hit, predict_taken, btb_target_out} !== {1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_after_lookup: got %h expected %h",
                     {btb_hit, predict_taken, btb_target_out}, {1'b0, 1'b0, 24'h0});
        end
        checks++;
        if (valid_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", valid_count);
        end
    endtask

    task automatic test_alloc();
        do_update(24'h000100, 1'b1, 24'h000200);
        look(24'h000100);
        checks++;
        if ({btb_hit, predict_taken, btb_target_out} !== {1'b1, 1'b1, 24'h000200}) begin
            errors++;
            $display("FAIL alloc_lookup: got %h expected %h",
                     {btb_hit, predict_taken, btb_target_out}, {1'b1, 1'b1, 24'h000200});
        end
        checks++;
        if (valid_count !== 4'd1) begin
            errors++;
            $display("FAIL alloc_count: got %0d expected 1", valid_count);
        end
        // Not-taken miss: no allocation.
        do_update(24'h000900, 1'b0, 24'h000999);
        look(24'h000900);
        checks++;
        if ({btb_hit, valid_count} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL nt_miss_noalloc: got %h expected %h",
                     {btb_hit, valid_count}, {1'b0, 4'd1});
        end
    endtask

    task automatic test_counter();
        // Expected predict_taken after each update starting from ctr=2:
        // NT->1, NT->0, NT->0, T->1, T->2, T->3, T->3, NT->2
        logic       dirs [8];
        logic       exp_pt [8];
        dirs   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_pt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_update(24'h000100, dirs[i], 24'h000200);
            look(24'h000100);
            checks++;
            if ({btb_hit, predict_taken} !== {1'b1, exp_pt[i]}) begin
                errors++;
                $display("FAIL ctr_step%0d: got hit/pt %b expected %b",
                         i, {btb_hit, predict_taken}, {1'b1, exp_pt[i]});
            end
        end
        // Not-taken update keeps target; taken hit rewrites it, no duplicate.
        do_update(24'h000100, 1'b0, 24'h000777);
        look(24'h000100);
        checks++;
        if (btb_target_out !== 24'h000200) begin
            errors++;
            $display("FAIL nt_keeps_target: got %h expected %h", btb_target_out, 24'h000200);
        end
        do_update(24'h000100, 1'b1, 24'h000345);
        look(24'h000100);
        checks++;
        if ({btb_target_out, valid_count} !== {24'h000345, 4'd1}) begin
            errors++;
            $display("FAIL taken_new_target: got %h expected %h",
                     {btb_target_out, valid_count}, {24'h000345, 4'd1});
        end
    endtask

    task automatic test_replace();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_update(24'h001000 + 24'(i * 16), 1'b1, 24'h002000 + 24'(i));
        end
        checks++;
        if (valid_count !== 4'd8) begin
            errors++;
            $display("FAIL full_count: got %0d expected 8", valid_count);
        end
        look(24'h001000);
        checks++;
        if (btb_hit !== 1'b0) begin
            errors++;
            $display("FAIL a0_evicted: got hit %b expected 0", btb_hit);
        end
        look(24'h001080);
        checks++;
        if ({btb_hit, btb_target_out} !== {1'b1, 24'h002008}) begin
            errors++;
            $display("FAIL a8_present: got %h expected %h",
                     {btb_hit, btb_target_out}, {1'b1, 24'h002008});
        end
        look(24'h001010);
        checks++;
        if ({btb_hit, btb_target_out} !== {1'b1, 24'h002001}) begin
            errors++;
            $display("FAIL a1_present: got %h expected %h",
                     {btb_hit, btb_target_out}, {1'b1, 24'h002001});
        end
        // Victim pointer now 1: the tenth PC displaces A1.
        do_update(24'h001090, 1'b1, 24'h002009);
        look(24'h001010);
        checks++;
        if (btb_hit !== 1'b0) begin
            errors++;
            $display("FAIL a1_evicted: got hit %b expected 0", btb_hit);
        end
        look(24'h001090);
        checks++;
        if ({btb_hit, btb_target_out, valid_count} !== {1'b1, 24'h002009, 4'd8}) begin
            errors++;
            $display("FAIL a9_present: got %h expected %h",
                     {btb_hit, btb_target_out, valid_count}, {1'b1, 24'h002009, 4'd8});
        end
        look(24'h001020);
        checks++;
        if ({btb_hit, btb_target_out} !== {1'b1, 24'h002002}) begin
            errors++;
            $display("FAIL a2_present: got %h expected %h",
                     {btb_hit, btb_target_out}, {1'b1, 24'h002002});
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_update(24'h003000 + 24'(i * 4), 1'b1, 24'h004000 + 24'(i));
        end
        checks++;
        if (valid_count !== 4'd4) begin
            errors++;
            $display("FAIL pre_flush_count: got %0d expected 4", valid_count);
        end
        flush = 1'b1;
        do_update(24'h005000, 1'b1, 24'h006000);
        flush = 1'b0;
        checks++;
        if (valid_count !== 4'd0) begin
            errors++;
            $display("FAIL flush_count: got %0d expected 0", valid_count);
        end
        for (int i = 0; i < 4; i++) begin
            look(24'h003000 + 24'(i * 4));
            checks++;
            if (btb_hit !== 1'b0) begin
                errors++;
                $display("FAIL flush_old%0d: got hit %b expected 0", i, btb_hit);
            end
        end
        look(24'h005000);
        checks++;
        if (btb_hit !== 1'b0) begin
            errors++;
            $display("FAIL flush_drops_update: got hit %b expected 0", btb_hit);
        end
        do_update(24'h003004, 1'b1, 24'h004444);
        look(24'h003004);
        checks++;
        if ({btb_hit, predict_taken, btb_target_out, valid_count} !==
            {1'b1, 1'b1, 24'h004444, 4'd1}) begin
            errors++;
            $display("FAIL realloc_after_flush: got %h expected %h",
                     {btb_hit, predict_taken, btb_target_out, valid_count},
                     {1'b1, 1'b1, 24'h004444, 4'd1});
        end
    endtask

    task automatic test_back_to_back();
        // Same-cycle lookup and allocation of one PC: no bypass.
        look(24'h007000);
        upd_valid  = 1'b1;
        upd_pc     = 24'h007000;
        upd_taken  = 1'b1;
        upd_target = 24'h008000;
        #1;
        checks++;
        if (btb_hit !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_hit: got %b expected 0", btb_hit);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        checks++;
        if ({btb_hit, btb_target_out} !== {1'b1, 24'h008000}) begin
            errors++;
            $display("FAIL next_cycle_hit: got %h expected %h",
                     {btb_hit, btb_target_out}, {1'b1, 24'h008000});
        end
        // Reset mid-stream while an update is presented.
        reset_n = 1'b0;
        do_update(24'h009000, 1'b1, 24'h00A000);
        reset_n = 1'b1;
        tick();
        look(24'h007000);
        checks++;
        if ({btb_hit, predict_taken, btb_target_out, valid_count} !==
            {1'b0, 1'b0, 24'h0, 4'd0}) begin
            errors++;
            $display("FAIL midreset_old: got %h expected %h",
                     {btb_hit, predict_taken, btb_target_out, valid_count},
                     {1'b0, 1'b0, 24'h0, 4'd0});
        end
        look(24'h009000);
        checks++;
        if (btb_hit !== 1'b0) begin
            errors++;
            $display("FAIL midreset_upd_lost: got hit %b expected 0", btb_hit);
        end
        // Normal operation resumes.
        do_update(24'h009000, 1'b1, 24'h00A000);
        look(24'h009000);
        checks++;
        if ({btb_hit, btb_target_out, valid_count} !== {1'b1, 24'h00A000, 4'd1}) begin
            errors++;
            $display("FAIL resume_after_reset: got %h expected %h",
                     {btb_hit, btb_target_out, valid_count}, {1'b1, 24'h00A000, 4'd1});
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset_n    = 1'b0;
        lookup_pc  = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        flush      = 1'b0;
        tick();
        test_reset();
        test_alloc();
        test_counter();
        test_replace();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/btb_sat.md
BTB_SAT -- requirements
Module: btb_sat

Interface
REQ-001 Parameter N_ENTRIES, default 8, number of fully-associative entries; power of two, minimum 2.
REQ-002 Parameter ADDR_WIDTH, default 24, width of PC and target fields.
REQ-003 Parameter CTR_INIT, default 2'b10, 2-bit counter value written on allocation.
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 lookup_pc  input  ADDR_WIDTH  fetch PC to predict.
REQ-007 btb_hit  output  1  a valid entry's tag equals lookup_pc.
REQ-008 predict_taken  output  1  btb_hit AND bit[1] of the matching entry's counter.
REQ-009 btb_target_out  output  ADDR_WIDTH  target of the matching entry, 0 when btb_hit=0.
REQ-010 upd_valid  input  1  resolved-branch update strobe.
REQ-011 upd_pc  input  ADDR_WIDTH  resolved branch PC.
REQ-012 upd_taken  input  1  resolved branch direction.
REQ-013 upd_target  input  ADDR_WIDTH  resolved branch target.
REQ-014 flush  input  1  invalidate all entries.
REQ-015 valid_count  output  $clog2(N_ENTRIES)+1  number of valid entries.

Function
REQ-016 Per entry state: valid bit, tag[ADDR_WIDTH], target[ADDR_WIDTH], 2-bit saturating counter; global victim pointer of $clog2(N_ENTRIES) bits.
REQ-017 Lookup is combinational, zero latency; only valid entries match; on multiple matches the lowest index wins.
REQ-018 Lookup reflects registered state only; an update in cycle T is visible to lookup from cycle T+1, with no bypass.
REQ-019 Update hit (upd_valid=1, valid entry with tag==upd_pc): counter +1 saturating at 3 if upd_taken, else -1 saturating at 0.
REQ-020 Update hit with upd_taken=1 also overwrites target with upd_target; tag, valid and victim pointer are unchanged.
REQ-021 Update miss with upd_taken=0: no state change.
REQ-022 Update miss with upd_taken=1: allocate an entry with valid=1, tag=upd_pc, target=upd_target, counter=CTR_INIT.
REQ-023 Allocation target: the lowest-index invalid entry if one exists (victim pointer unchanged); otherwise the entry at the victim pointer, which then increments modulo N_ENTRIES.
REQ-024 Allocation never creates a duplicate tag, so REQ-017 priority applies only to corrupted state.
REQ-025 flush=1: all valid bits clear at the next edge; tags, targets, counters and the victim pointer are retained.
REQ-026 flush and upd_valid in the same cycle: flush wins and the update is dropped.
REQ-027 valid_count is registered and equals the popcount of the valid bits after each edge; its range is 0..N_ENTRIES.
REQ-028 upd_pc==lookup_pc in the same cycle is legal; the lookup returns pre-update state.

Reset
REQ-029 reset_n=0 at a clock edge clears all valid bits, zeroes all tags, targets and counters, and sets the victim pointer to 0 and valid_count to 0.
REQ-030 Reset has priority over flush and update; an update presented during reset is lost.
REQ-031 During and after reset: btb_hit=0, predict_taken=0, btb_target_out=0.
REQ-032 reset_n deasserting mid-stream resumes normal operation on the first edge with reset_n=1.

Verification
REQ-033 Reset, then lookup 0x000100 -> btb_hit=0, predict_taken=0, btb_target_out=0, valid_count=0.
REQ-034 Update pc=0x000100, taken, target=0x000200; next cycle lookup 0x000100 -> hit=1, predict_taken=1 (ctr=2), target=0x000200, valid_count=1.
REQ-035 Three not-taken updates to 0x000100 -> ctr goes 2->1->0->0 and predict_taken=0 after the first; one taken update -> ctr=1, still not taken; two more taken -> predict_taken=1, ctr saturates at 3 after a fourth.
REQ-036 Default N_ENTRIES=8: allocate 9 distinct taken PCs A0..A8 -> A8 replaces entry 0 (A0 misses), victim pointer=1, valid_count=8; a 10th PC replaces entry 1.
REQ-037 flush and a taken update to a new PC asserted together with 4 entries valid -> next cycle valid_count=0 and all lookups miss, including the new PC.
REQ-038 Lookup and taken update of the same new PC in one cycle -> hit=0 that cycle, hit=1 the next; reset_n=0 mid-sequence -> all lookups miss afterwards.
